// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: paddle, ball, serve/play/miss/game-over and score counters.
// Optional PONG_SPEEDUP_EN: ball step grows by one every fourth paddle hit, capped at 6.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 40,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int MISS_HOLD    = 60,
  parameter int MAX_MISSES   = 3
) (
  input  logic       clk_pxl,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_serve,
  output logic [9:0] paddle0_pos_y,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [7:0] hit_count,
  output logic [3:0] miss_count,
  output logic [1:0] game_state
);

  // state    | meaning
  // SERVE    | ball parked at centre, waiting for a serve edge
  // PLAY     | ball moving, bounces and paddle collision active
  // MISS     | ball frozen at left wall for MISS_HOLD frames
  // GAMEOVER | ball and paddle frozen until a serve edge restarts
  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [9:0]  PAD_RST   = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]  X_CTR     = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR     = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] PAD_MAX   = 11'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]  PAD_MAX10 = 10'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  X_MAX10   = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  Y_MAX10   = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] PAD_SPD   = 11'(PADDLE_SPEED);
  localparam logic [9:0]  PAD_SPD10 = 10'(PADDLE_SPEED);
  localparam logic [10:0] PAD_WID   = 11'(PADDLE_W);
  localparam logic [9:0]  PAD_WID10 = 10'(PADDLE_W);
  localparam logic [10:0] PAD_HGT   = 11'(PADDLE_H);
  localparam logic [10:0] BALL_SZ   = 11'(BALL_SIZE);
  localparam logic [2:0]  STEP_RST  = 3'(BALL_SPEED);
  localparam logic [7:0]  HOLD_LAST = 8'(MISS_HOLD - 1);
  localparam logic [3:0]  MISS_LIM  = 4'(MAX_MISSES);

  logic [9:0] pad_q, pad_d, x_q, x_d, y_q, y_d;
  logic       dx_q, dx_d, dy_q, dy_d, serve_q, serve_d;
  logic [7:0] hit_q, hit_d, hold_q, hold_d;
  logic [3:0] miss_q, miss_d;
  logic [1:0] state_q, state_d;
  logic [2:0] step;

`ifdef PONG_SPEEDUP_EN
  logic [2:0] step_q, step_d;
  assign step = step_q;
`else
  assign step = STEP_RST;
`endif

  logic [10:0] pad_w, x_w, y_w, step_w, x_next, y_next;
  logic        serve_edge, overlap, enter_serve;

  assign pad_w  = {1'b0, pad_q};
  assign x_w    = {1'b0, x_q};
  assign y_w    = {1'b0, y_q};
  assign step_w = {8'd0, step};

  always_comb begin
    pad_d       = pad_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    state_d     = state_q;
    hold_d      = hold_q;
    serve_d     = serve_q;
`ifdef PONG_SPEEDUP_EN
    step_d      = step_q;
`endif
    enter_serve = 1'b0;
    serve_edge  = btn_serve & ~serve_q;
    // collision is judged against the paddle position before this frame's move
    overlap     = ((y_w + BALL_SZ) > pad_w) && (y_w < (pad_w + PAD_HGT));
    x_next      = dx_q ? (x_w + step_w) : (x_w - step_w);
    y_next      = dy_q ? (y_w + step_w) : (y_w - step_w);

    if (frame_tick) begin
      serve_d = btn_serve;
      if (state_q != ST_OVER) begin
        if (btn_up && !btn_down)
          pad_d = (pad_w <= PAD_SPD) ? 10'd0 : (pad_q - PAD_SPD10);
        else if (btn_down && !btn_up)
          pad_d = ((pad_w + PAD_SPD) >= PAD_MAX) ? PAD_MAX10 : (pad_q + PAD_SPD10);
      end

      case (state_q)
        ST_SERVE: begin
          x_d = X_CTR;
          y_d = Y_CTR;
          if (serve_edge) begin
            state_d = ST_PLAY;
            dx_d    = 1'b1;
            dy_d    = 1'b1;
          end
        end
        ST_PLAY: begin
          if (dx_q) begin
            if (x_next >= X_MAX) begin
              x_d  = X_MAX10;
              dx_d = 1'b0;
            end else begin
              x_d = x_next[9:0];
            end
          end else if (x_w <= (PAD_WID + step_w)) begin
            if (overlap) begin
              x_d  = PAD_WID10;
              dx_d = 1'b1;
              if (hit_q != 8'hFF) begin
                hit_d = hit_q + 8'd1;
`ifdef PONG_SPEEDUP_EN
                if (hit_q[1:0] == 2'b11 && step_q < 3'd6)
                  step_d = step_q + 3'd1;
`endif
              end
            end else begin
              x_d     = 10'd0;
              state_d = ST_MISS;
              hold_d  = 8'd0;
              miss_d  = miss_q + 4'd1;
            end
          end else begin
            x_d = x_next[9:0];
          end

          if (!dy_q) begin
            if (y_w <= step_w) begin
              y_d  = 10'd0;
              dy_d = 1'b1;
            end else begin
              y_d = y_next[9:0];
            end
          end else if (y_next >= Y_MAX) begin
            y_d  = Y_MAX10;
            dy_d = 1'b0;
          end else begin
            y_d = y_next[9:0];
          end
        end
        ST_MISS: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = 8'd0;
            if (miss_q == MISS_LIM) begin
              state_d = ST_OVER;
            end else begin
              state_d     = ST_SERVE;
              enter_serve = 1'b1;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        ST_OVER: begin
          if (serve_edge) begin
            hit_d       = 8'd0;
            miss_d      = 4'd0;
            state_d     = ST_SERVE;
            enter_serve = 1'b1;
          end
        end
        default: state_d = ST_SERVE;
      endcase

      if (enter_serve) begin
        x_d = X_CTR;
        y_d = Y_CTR;
`ifdef PONG_SPEEDUP_EN
        step_d = STEP_RST;
`endif
      end
    end
  end

  always_ff @(posedge clk_pxl or negedge reset_n) begin
    if (!reset_n) begin
      pad_q   <= PAD_RST;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      hit_q   <= 8'd0;
      miss_q  <= 4'd0;
      state_q <= ST_SERVE;
      hold_q  <= 8'd0;
      serve_q <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      step_q  <= STEP_RST;
`endif
    end else begin
      pad_q   <= pad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      serve_q <= serve_d;
`ifdef PONG_SPEEDUP_EN
      step_q  <= step_d;
`endif
    end
  end

  assign paddle0_pos_y = pad_q;
  assign ball_pos_x    = x_q;
  assign ball_pos_y    = y_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
  assign game_state    = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: behavioural game model feeds a scoreboard of
// per-frame expected outputs, plus fixed-value checks at the interesting frames.
module tb_pong_game_ctrl;

  logic       clk_pxl = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_serve = 1'b0;
  logic [9:0] paddle0_pos_y, ball_pos_x, ball_pos_y;
  logic [7:0] hit_count;
  logic [3:0] miss_count;
  logic [1:0] game_state;

  pong_game_ctrl dut (
    .clk_pxl      (clk_pxl),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_serve    (btn_serve),
    .paddle0_pos_y(paddle0_pos_y),
    .ball_pos_x   (ball_pos_x),
    .ball_pos_y   (ball_pos_y),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .game_state   (game_state)
  );

  always #5 clk_pxl = ~clk_pxl;

  typedef struct {
    int pad; int x; int y; int hit; int miss; int st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_pad, m_x, m_y, m_dx, m_dy, m_hit, m_miss, m_st, m_hold, m_step;
  logic m_sq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pad = 220; m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_hit = 0; m_miss = 0; m_st = 0; m_hold = 0; m_step = 2; m_sq = 1'b0;
  endtask

  task automatic model_tick(input logic up, input logic dn, input logic sv);
    int px, x0, y0;
    logic sedge;
    sedge = sv && !m_sq;
    m_sq  = sv;
    px = m_pad; x0 = m_x; y0 = m_y;
    if (m_st != 3) begin
      if (up && !dn)      m_pad = (px >= 4) ? px - 4 : 0;
      else if (dn && !up) m_pad = (px + 4 <= 440) ? px + 4 : 440;
    end
    case (m_st)
      0: begin
        m_x = 316; m_y = 236;
        if (sedge) begin m_st = 1; m_dx = 1; m_dy = 1; end
      end
      1: begin
        if (m_dx == 1) begin
          if (x0 + m_step >= 632) begin m_x = 632; m_dx = 0; end
          else m_x = x0 + m_step;
        end else if (x0 <= 10 + m_step) begin
          if (y0 + 8 > px && y0 < px + 40) begin
            m_x = 10; m_dx = 1;
            if (m_hit < 255) begin
              m_hit++;
`ifdef PONG_SPEEDUP_EN
              if (m_hit % 4 == 0 && m_step < 6) m_step++;
`endif
            end
          end else begin
            m_x = 0; m_st = 2; m_hold = 0; m_miss++;
          end
        end else m_x = x0 - m_step;
        if (m_dy == 0) begin
          if (y0 <= m_step) begin m_y = 0; m_dy = 1; end
          else m_y = y0 - m_step;
        end else begin
          if (y0 + m_step >= 472) begin m_y = 472; m_dy = 0; end
          else m_y = y0 + m_step;
        end
      end
      2: begin
        if (m_hold == 59) begin
          m_hold = 0;
          if (m_miss == 3) m_st = 3;
          else begin m_st = 0; m_x = 316; m_y = 236; m_step = 2; end
        end else m_hold++;
      end
      default: begin
        if (sedge) begin
          m_hit = 0; m_miss = 0; m_st = 0; m_x = 316; m_y = 236; m_step = 2;
        end
      end
    endcase
  endtask

  task automatic push_model();
    exp_t e;
    e.pad = m_pad; e.x = m_x; e.y = m_y; e.hit = m_hit; e.miss = m_miss; e.st = m_st;
    sb_q.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".pad"},  32'(paddle0_pos_y), 32'(e.pad));
    chk({tag, ".x"},    32'(ball_pos_x),    32'(e.x));
    chk({tag, ".y"},    32'(ball_pos_y),    32'(e.y));
    chk({tag, ".hit"},  32'(hit_count),     32'(e.hit));
    chk({tag, ".miss"}, 32'(miss_count),    32'(e.miss));
    chk({tag, ".st"},   32'(game_state),    32'(e.st));
  endtask

  // One frame: tick cycle, check result, then one idle cycle that must hold.
  task automatic tick(input logic up, input logic dn, input logic sv);
    @(negedge clk_pxl);
    btn_up = up; btn_down = dn; btn_serve = sv; frame_tick = 1'b1;
    model_tick(up, dn, sv);
    push_model();
    @(negedge clk_pxl);
    frame_tick = 1'b0;
    check_sb("tick");
    push_model();
    @(negedge clk_pxl);
    check_sb("idle");
  endtask

  // mode 0 chases the ball with the paddle, mode 1 keeps well clear of it
  task automatic steer(input int mode, output logic up, output logic dn);
    int target;
    if (mode == 0) target = m_y - 16;
    else           target = (m_y < 220) ? m_y + 100 : m_y - 100;
    if (target < 0)   target = 0;
    if (target > 440) target = 440;
    up = (m_pad > target + 3);
    dn = (m_pad < target - 3);
  endtask

  task automatic timeout(input string tag);
    checks++; errors++;
    $display("FAIL %s: frame budget expired, got no event expected one", tag);
  endtask

  initial begin
    logic u, d, sv;
    int   n, saved_pad;
    model_reset();
    repeat (3) @(negedge clk_pxl);
    reset_n = 1'b1;
    @(negedge clk_pxl);
    chk("rst.pad", 32'(paddle0_pos_y), 32'd220);
    chk("rst.x",   32'(ball_pos_x),    32'd316);
    chk("rst.y",   32'(ball_pos_y),    32'd236);
    chk("rst.hit", 32'(hit_count),     32'd0);
    chk("rst.miss",32'(miss_count),    32'd0);
    chk("rst.st",  32'(game_state),    32'd0);

    tick(1'b0, 1'b0, 1'b1);
    chk("serve.st", 32'(game_state), 32'd1);
    chk("serve.x",  32'(ball_pos_x), 32'd316);
    chk("serve.y",  32'(ball_pos_y), 32'd236);
    for (int k = 1; k <= 159; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (k == 1)   begin chk("mv1.x", 32'(ball_pos_x), 32'd318); chk("mv1.y", 32'(ball_pos_y), 32'd238); end
      if (k == 118) chk("ybounce.y", 32'(ball_pos_y), 32'd472);
      if (k == 158) chk("xwall.x",   32'(ball_pos_x), 32'd632);
      if (k == 159) chk("xback.x",   32'(ball_pos_x), 32'd630);
    end

    for (int k = 1; k <= 60; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (k == 54) chk("pad54", 32'(paddle0_pos_y), 32'd4);
      if (k == 55) chk("pad55", 32'(paddle0_pos_y), 32'd0);
      if (k == 60) chk("pad60", 32'(paddle0_pos_y), 32'd0);
    end
    for (int k = 1; k <= 3; k++) tick(1'b1, 1'b1, 1'b0);
    chk("padboth", 32'(paddle0_pos_y), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    chk("paddown", 32'(paddle0_pos_y), 32'd4);

    n = 0;
    while (m_hit < 1 && m_st == 1 && n < 2000) begin
      steer(0, u, d); tick(u, d, 1'b0); n++;
    end
    if (m_hit < 1) timeout("first_hit");
    else begin
      chk("hit.cnt", 32'(hit_count),  32'd1);
      chk("hit.x",   32'(ball_pos_x), 32'd10);
    end

    for (int r = 1; r <= 3; r++) begin
      if (r > 1) begin
        tick(1'b0, 1'b0, 1'b1);
        chk("reserve.st", 32'(game_state), 32'd1);
      end
      n = 0;
      while (m_st == 1 && n < 3000) begin
        steer(1, u, d); tick(u, d, 1'b0); n++;
      end
      if (m_st != 2) timeout("miss");
      else begin
        chk("miss.st",  32'(game_state), 32'd2);
        chk("miss.cnt", 32'(miss_count), 32'(r));
        chk("miss.x",   32'(ball_pos_x), 32'd0);
      end
      for (int h = 1; h <= 60; h++) begin
        sv = (r == 3 && h >= 55);
        tick(1'b0, 1'b0, sv);
        if (h == 59) chk("hold59.st", 32'(game_state), 32'd2);
        if (h == 60 && r < 3) begin
          chk("hold60.st", 32'(game_state), 32'd0);
          chk("hold60.x",  32'(ball_pos_x), 32'd316);
        end
        if (h == 60 && r == 3) chk("over.st", 32'(game_state), 32'd3);
      end
    end

    saved_pad = m_pad;
    for (int k = 1; k <= 3; k++) tick(1'b0, 1'b1, 1'b1);
    chk("over.hold.st", 32'(game_state),    32'd3);
    chk("over.pad",     32'(paddle0_pos_y), 32'(saved_pad));
    tick(1'b0, 1'b0, 1'b0);
    chk("over.rel.st", 32'(game_state), 32'd3);
    tick(1'b0, 1'b0, 1'b1);
    chk("restart.st",   32'(game_state), 32'd0);
    chk("restart.hit",  32'(hit_count),  32'd0);
    chk("restart.miss", 32'(miss_count), 32'd0);
    tick(1'b0, 1'b0, 1'b1);
    chk("nosecond.st", 32'(game_state), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("play2.st", 32'(game_state), 32'd1);
    for (int k = 1; k <= 5; k++) tick(1'b1, 1'b0, 1'b0);

    @(negedge clk_pxl);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.pad", 32'(paddle0_pos_y), 32'd220);
    chk("arst.x",   32'(ball_pos_x),    32'd316);
    chk("arst.y",   32'(ball_pos_y),    32'd236);
    chk("arst.hit", 32'(hit_count),     32'd0);
    chk("arst.miss",32'(miss_count),    32'd0);
    chk("arst.st",  32'(game_state),    32'd0);
    model_reset();
    @(negedge clk_pxl);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("post.x", 32'(ball_pos_x), 32'd318);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
